axi4lite_csr_slave: RTL

AXI4LITE_CSR_SLAVE -- requirements
Module: axi4lite_csr_slave

---
 rtl/axi4lite_csr_pkg.sv | 52 +++++
 rtl/axi4lite_csr_slave.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4lite_csr_pkg.sv
// Shared definitions for the AXI4-lite CSR slave: register map, response
// codes, FSM state types and the byte-merge helper used on writes.
package axi4lite_csr_pkg;

  // Word indices of the implemented registers
  localparam int unsigned IDX_ID       = 0;
  localparam int unsigned IDX_SCRATCH  = 1;
  localparam int unsigned IDX_CTRL     = 2;
  localparam int unsigned IDX_COUNTER  = 3;
  localparam int unsigned IDX_WR_COUNT = 4;
  localparam int unsigned IDX_USER0    = 5;
  localparam int unsigned IDX_USER1    = 6;
  localparam int unsigned IDX_USER2    = 7;

  // CTRL register bit positions
  localparam int unsigned CTRL_CNT_EN  = 0;
  localparam int unsigned CTRL_CNT_CLR = 1;

  // AXI response codes
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Data returned for reads outside the implemented range
  localparam logic [31:0] RDATA_DEFAULT = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    W_IDLE,
    W_HAVE_AW,
    W_HAVE_W,
    W_RESP
  } w_state_e;

  typedef enum logic {
    R_IDLE,
    R_RESP
  } r_state_e;

  // Replace only the bytes of oldVal whose strobe bit is set
  function automatic logic [31:0] mergeBytes(input logic [31:0] oldVal,
                                             input logic [31:0] newVal,
                                             input logic [3:0]  strb);
    logic [31:0] merged;
    merged = oldVal;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) begin
        merged[8*b +: 8] = newVal[8*b +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/axi4lite_csr_slave.sv
// AXI4-lite slave exposing a small word-indexed CSR block: ID, scratch,
// control, a free-running counter, a write counter and three user registers.
// Write and read channels run independent FSMs so both can be busy at once.
module axi4lite_csr_slave
  import axi4lite_csr_pkg::*;
#(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned NUM_REGS = 8,
  parameter logic [31:0] ID_VALUE = 32'hACCE_0001
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [31:0]       s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [31:0]       s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic [31:0]       user_reg0,
  output logic [31:0]       user_reg1,
  output logic [31:0]       user_reg2
);

  // Index lies inside the implemented register window
  function automatic logic inRange(input logic [ADDR_W-1:0] a);
    return 64'(a) < 64'(NUM_REGS);
  endfunction

  // Index selects register k
  function automatic logic isIdx(input logic [ADDR_W-1:0] a, input int unsigned k);
    return 64'(a) == 64'(k);
  endfunction

  w_state_e          wrState_q;
  logic              awReady_q;
  logic              wReady_q;
  logic              bValid_q;
  logic [1:0]        bResp_q;
  logic [ADDR_W-1:0] awAddr_q;
  logic [31:0]       wData_q;
  logic [3:0]        wStrb_q;

  r_state_e          rdState_q;
  logic              arReady_q;
  logic              rValid_q;
  logic [31:0]       rData_q;
  logic [1:0]        rResp_q;

  logic [31:0]       scratch_q, scratch_d;
  logic              cntEn_q, cntEn_d;
  logic [31:0]       counter_q, counter_d;
  logic [31:0]       wrCount_q, wrCount_d;
  logic [31:0]       user0_q, user0_d;
  logic [31:0]       user1_q, user1_d;
  logic [31:0]       user2_q, user2_d;

  logic              awHs;
  logic              wHs;
  logic              wrCommit;
  logic              wrHit;
  logic [ADDR_W-1:0] wrAddr;
  logic [31:0]       wrData;
  logic [3:0]        wrStrb;
  logic [31:0]       rdValue;
  logic [1:0]        rdResp;

  assign awHs = s_axi_awvalid && awReady_q;
  assign wHs  = s_axi_wvalid && wReady_q;

  // A write commits on the edge where the second of its two halves arrives
  assign wrCommit = ((wrState_q == W_IDLE)    && awHs && wHs) ||
                    ((wrState_q == W_HAVE_AW) && wHs) ||
                    ((wrState_q == W_HAVE_W)  && awHs);

  assign wrAddr = (wrState_q == W_HAVE_AW) ? awAddr_q : s_axi_awaddr;
  assign wrData = (wrState_q == W_HAVE_W)  ? wData_q  : s_axi_wdata;
  assign wrStrb = (wrState_q == W_HAVE_W)  ? wStrb_q  : s_axi_wstrb;
  assign wrHit  = wrCommit && inRange(wrAddr);

  // Write channel FSM: collect AW and W in any order, then hold the response
  always_ff @(posedge clk) begin
    if (rst) begin
      wrState_q <= W_IDLE;
      awReady_q <= 1'b1;
      wReady_q  <= 1'b1;
      bValid_q  <= 1'b0;
      bResp_q   <= RESP_OKAY;
      awAddr_q  <= '0;
      wData_q   <= '0;
      wStrb_q   <= '0;
    end else begin
      case (wrState_q)
        W_IDLE: begin
          if (awHs && wHs) begin
            wrState_q <= W_RESP;
            awReady_q <= 1'b0;
            wReady_q  <= 1'b0;
            bValid_q  <= 1'b1;
            bResp_q   <= inRange(wrAddr) ? RESP_OKAY : RESP_SLVERR;
          end else if (awHs) begin
            wrState_q <= W_HAVE_AW;
            awReady_q <= 1'b0;
            awAddr_q  <= s_axi_awaddr;
          end else if (wHs) begin
            wrState_q <= W_HAVE_W;
            wReady_q  <= 1'b0;
            wData_q   <= s_axi_wdata;
            wStrb_q   <= s_axi_wstrb;
          end
        end
        W_HAVE_AW: begin
          if (wHs) begin
            wrState_q <= W_RESP;
            wReady_q  <= 1'b0;
            bValid_q  <= 1'b1;
            bResp_q   <= inRange(wrAddr) ? RESP_OKAY : RESP_SLVERR;
          end
        end
        W_HAVE_W: begin
          if (awHs) begin
            wrState_q <= W_RESP;
            awReady_q <= 1'b0;
            bValid_q  <= 1'b1;
            bResp_q   <= inRange(wrAddr) ? RESP_OKAY : RESP_SLVERR;
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            wrState_q <= W_IDLE;
            awReady_q <= 1'b1;
            wReady_q  <= 1'b1;
            bValid_q  <= 1'b0;
          end
        end
        default: begin
          wrState_q <= W_IDLE;
        end
      endcase
    end
  end

  // Register file next state: counter ticking, write-commit updates, clear priority
  always_comb begin
    scratch_d = scratch_q;
    cntEn_d   = cntEn_q;
    counter_d = counter_q;
    wrCount_d = wrCount_q;
    user0_d   = user0_q;
    user1_d   = user1_q;
    user2_d   = user2_q;

    if (cntEn_q) begin
      counter_d = counter_q + 32'd1;
    end

    if (wrCommit) begin
      wrCount_d = wrCount_q + 32'd1;
    end

    if (wrHit) begin
      if (isIdx(wrAddr, IDX_SCRATCH)) begin
        scratch_d = mergeBytes(scratch_q, wrData, wrStrb);
      end
      if (isIdx(wrAddr, IDX_CTRL) && wrStrb[0]) begin
        cntEn_d = wrData[CTRL_CNT_EN];
        if (wrData[CTRL_CNT_CLR]) begin
          counter_d = '0;
        end
      end
      if (isIdx(wrAddr, IDX_USER0)) begin
        user0_d = mergeBytes(user0_q, wrData, wrStrb);
      end
      if (isIdx(wrAddr, IDX_USER1)) begin
        user1_d = mergeBytes(user1_q, wrData, wrStrb);
      end
      if (isIdx(wrAddr, IDX_USER2)) begin
        user2_d = mergeBytes(user2_q, wrData, wrStrb);
      end
    end
  end

  // Register file storage
  always_ff @(posedge clk) begin
    if (rst) begin
      scratch_q <= '0;
      cntEn_q   <= 1'b0;
      counter_q <= '0;
      wrCount_q <= '0;
      user0_q   <= '0;
      user1_q   <= '0;
      user2_q   <= '0;
    end else begin
      scratch_q <= scratch_d;
      cntEn_q   <= cntEn_d;
      counter_q <= counter_d;
      wrCount_q <= wrCount_d;
      user0_q   <= user0_d;
      user1_q   <= user1_d;
      user2_q   <= user2_d;
    end
  end

  // Read decode from current register outputs, so a same-edge write is not visible
  always_comb begin
    rdValue = '0;
    rdResp  = RESP_OKAY;
    if (!inRange(s_axi_araddr)) begin
      rdValue = RDATA_DEFAULT;
      rdResp  = RESP_SLVERR;
    end else if (isIdx(s_axi_araddr, IDX_ID)) begin
      rdValue = ID_VALUE;
    end else if (isIdx(s_axi_araddr, IDX_SCRATCH)) begin
      rdValue = scratch_q;
    end else if (isIdx(s_axi_araddr, IDX_CTRL)) begin
      rdValue = {31'd0, cntEn_q};
    end else if (isIdx(s_axi_araddr, IDX_COUNTER)) begin
      rdValue = counter_q;
    end else if (isIdx(s_axi_araddr, IDX_WR_COUNT)) begin
      rdValue = wrCount_q;
    end else if (isIdx(s_axi_araddr, IDX_USER0)) begin
      rdValue = user0_q;
    end else if (isIdx(s_axi_araddr, IDX_USER1)) begin
      rdValue = user1_q;
    end else if (isIdx(s_axi_araddr, IDX_USER2)) begin
      rdValue = user2_q;
    end
  end

  // Read channel FSM: capture data on AR handshake and hold it until taken
  always_ff @(posedge clk) begin
    if (rst) begin
      rdState_q <= R_IDLE;
      arReady_q <= 1'b1;
      rValid_q  <= 1'b0;
      rData_q   <= '0;
      rResp_q   <= RESP_OKAY;
    end else begin
      case (rdState_q)
        R_IDLE: begin
          if (s_axi_arvalid) begin
            rdState_q <= R_RESP;
            arReady_q <= 1'b0;
            rValid_q  <= 1'b1;
            rData_q   <= rdValue;
            rResp_q   <= rdResp;
          end
        end
        R_RESP: begin
          if (s_axi_rready) begin
            rdState_q <= R_IDLE;
            arReady_q <= 1'b1;
            rValid_q  <= 1'b0;
          end
        end
        default: begin
          rdState_q <= R_IDLE;
        end
      endcase
    end
  end

  assign s_axi_awready = awReady_q;
  assign s_axi_wready  = wReady_q;
  assign s_axi_bvalid  = bValid_q;
  assign s_axi_bresp   = bResp_q;
  assign s_axi_arready = arReady_q;
  assign s_axi_rvalid  = rValid_q;
  assign s_axi_rdata   = rData_q;
  assign s_axi_rresp   = rResp_q;

  assign user_reg0 = user0_q;
  assign user_reg1 = user1_q;
  assign user_reg2 = user2_q;

endmodule
